// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word width, nop encoding, reset PC and the
// fetch queue entry payload.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_3000;

    // One buffered fetch: instruction word with its address
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fq_entry_t;

    // Sequential PC of an instruction, wrapping modulo 2^32
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(4);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue. The slave modport is the
// queue itself; the master modport is the fetch/decode environment.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    import mips_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              In_Valid;
    logic              In_Ready;
    logic [WORD_W-1:0] In_Instr;
    logic [WORD_W-1:0] In_PC;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [WORD_W-1:0] Out_Instr;
    logic [WORD_W-1:0] Out_PC;
    logic [WORD_W-1:0] Out_PC4;
    logic              Flush;
    logic [CNT_W-1:0]  Count;

    modport slave (
        input  In_Valid, In_Instr, In_PC, Out_Ready, Flush,
        output In_Ready, Out_Valid, Out_Instr, Out_PC, Out_PC4, Count
    );

    modport master (
        output In_Valid, In_Instr, In_PC, Out_Ready, Flush,
        input  In_Ready, Out_Valid, Out_Instr, Out_PC, Out_PC4, Count
    );

endinterface

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read
// port, asynchronously cleared to zero by reset.
module fq_storage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  fq_entry_t         wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output fq_entry_t         rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Entry write; reset wipes every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer of DEPTH
// {instr, pc} entries, in-order delivery, flush on redirect.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a word cross an empty
// queue in the same cycle it is presented.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             live_q;

    logic      empty_c, full_c, bypass_c;
    logic      out_valid_c, push_c, pop_c, wr_en_c, rd_en_c;
    fq_entry_t in_entry_c, head_c, out_entry_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_c = empty_c && live_q && !bus.Flush;
`else
    assign bypass_c = 1'b0;
`endif

    // live_q holds In_Ready low until the first edge after reset release
    assign bus.In_Ready = live_q && !full_c && !bus.Flush;
    assign out_valid_c  = live_q && !bus.Flush && (!empty_c || (bypass_c && bus.In_Valid));

    assign push_c  = bus.In_Valid && bus.In_Ready;
    assign pop_c   = out_valid_c && bus.Out_Ready;
    // A bypassed word that decode takes is never stored
    assign wr_en_c = push_c && !(bypass_c && pop_c);
    assign rd_en_c = pop_c && !bypass_c;

    assign in_entry_c.instr = bus.In_Instr;
    assign in_entry_c.pc    = bus.In_PC;
    assign out_entry_c      = bypass_c ? in_entry_c : head_c;

    assign bus.Out_Valid = out_valid_c;
    assign bus.Out_Instr = out_valid_c ? out_entry_c.instr : INSTR_NOP;
    assign bus.Out_PC    = out_valid_c ? out_entry_c.pc : '0;
    assign bus.Out_PC4   = out_valid_c ? pc_plus4(out_entry_c.pc) : '0;
    assign bus.Count     = count_q;

    fq_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_storage (
        .clk     (Clk),
        .rst_n   (Reset),
        .we_i    (wr_en_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_c)
    );

    // Pointer/occupancy next state; flush overrides any transfer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en_c && !rd_en_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!wr_en_c && rd_en_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and a randomized phase, all checked against a queue model.
module tb_fetch_queue;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        ir;
        logic        ov;
        logic [31:0] oins;
        logic [31:0] cnt;
    } vec_t;

    logic Clk;
    logic Reset;
    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        live  = 1'b0;
    logic [63:0] sb [$];
    vec_t        tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic ir,
                                input logic ov, input logic [31:0] oins, input logic [31:0] cnt);
        vec_t v;
        v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.ir = ir; v.ov = ov; v.oins = oins; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of inputs, check outputs against the model, update model
    task automatic drive_check(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                               input logic ordy, input logic fl);
        logic        exp_ir, exp_ov, byp, push, pop;
        logic [63:0] head;
        bus.In_Valid  = iv;
        bus.In_Instr  = ins;
        bus.In_PC     = pc;
        bus.Out_Ready = ordy;
        bus.Flush     = fl;
        #1;
        byp    = BYP && live && (sb.size() == 0) && !fl;
        exp_ir = live && (sb.size() != int'(DEPTH)) && !fl;
        exp_ov = live && !fl && ((sb.size() != 0) || (byp && iv));
        if (!exp_ov)             head = '0;
        else if (sb.size() != 0) head = sb[0];
        else                     head = {ins, pc};
        chk("in_ready",  32'(bus.In_Ready),  32'(exp_ir));
        chk("out_valid", 32'(bus.Out_Valid), 32'(exp_ov));
        chk("count",     32'(bus.Count),     32'(sb.size()));
        chk("out_instr", bus.Out_Instr, head[63:32]);
        chk("out_pc",    bus.Out_PC,    head[31:0]);
        chk("out_pc4",   bus.Out_PC4,   exp_ov ? head[31:0] + 32'd4 : 32'd0);
        push = iv && exp_ir;
        pop  = exp_ov && ordy;
        if (pop && sb.size() != 0) void'(sb.pop_front());
        if (push && !(byp && pop)) sb.push_back({ins, pc});
        if (fl) sb.delete();
    endtask

    task automatic tick();
        @(posedge Clk);
        live = Reset;
        @(negedge Clk);
    endtask

    initial begin
        logic [31:0] rpc;

        // Fill/drain, full back-pressure, flush and restart (DEPTH = 4)
        tbl[0]  = mk(1, 32'h34670404, 32'h3000, 0, 0, 1, BYP, BYP ? 32'h34670404 : 32'h0, 0);
        tbl[1]  = mk(1, 32'h24010001, 32'h3004, 0, 0, 1, 1, 32'h34670404, 1);
        tbl[2]  = mk(0, 32'h0,        32'h0,    0, 0, 1, 1, 32'h34670404, 2);
        tbl[3]  = mk(1, 32'h00851020, 32'h3008, 0, 0, 1, 1, 32'h34670404, 2);
        tbl[4]  = mk(1, 32'h8c090000, 32'h300c, 0, 0, 1, 1, 32'h34670404, 3);
        tbl[5]  = mk(1, 32'hac0a0004, 32'h3010, 0, 0, 0, 1, 32'h34670404, 4);
        tbl[6]  = mk(1, 32'hac0a0004, 32'h3010, 1, 0, 0, 1, 32'h34670404, 4);
        tbl[7]  = mk(1, 32'hac0a0004, 32'h3010, 0, 0, 1, 1, 32'h24010001, 3);
        tbl[8]  = mk(0, 32'h0,        32'h0,    1, 0, 0, 1, 32'h24010001, 4);
        tbl[9]  = mk(1, 32'h1000ffff, 32'h3014, 1, 1, 0, 0, 32'h0, 3);
        tbl[10] = mk(0, 32'h0,        32'h0,    0, 0, 1, 0, 32'h0, 0);
        tbl[11] = mk(1, 32'h3c1f0040, 32'h3040, 0, 0, 1, BYP, BYP ? 32'h3c1f0040 : 32'h0, 0);
        tbl[12] = mk(0, 32'h0,        32'h0,    1, 0, 1, 1, 32'h3c1f0040, 1);
        tbl[13] = mk(0, 32'h0,        32'h0,    0, 0, 1, 0, 32'h0, 0);

        Reset = 1'b0;
        bus.In_Valid = 1'b0; bus.In_Instr = '0; bus.In_PC = '0;
        bus.Out_Ready = 1'b0; bus.Flush = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_count",     32'(bus.Count),     32'd0);
        chk("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
        chk("rst_in_ready",  32'(bus.In_Ready),  32'd0);
        chk("rst_out_instr", bus.Out_Instr,      INSTR_NOP);
        Reset = 1'b1;
        drive_check(0, 0, 0, 0, 0);
        tick();
        drive_check(0, 0, 0, 0, 0);
        chk("post_rst_in_ready", 32'(bus.In_Ready), 32'd1);
        tick();

        for (int i = 0; i < 14; i++) begin
            drive_check(tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_in_ready", i),  32'(bus.In_Ready),  32'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.Out_Valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_instr", i), bus.Out_Instr, tbl[i].oins);
            chk($sformatf("tbl%0d_count", i),     32'(bus.Count), tbl[i].cnt);
            tick();
        end

        // Streaming: 10 words back to back, both sides always ready
        for (int i = 0; i < 10; i++) begin
            drive_check(1, 32'h20000000 + 32'(i), RESET_PC + 32'(4 * i), 1, 0);
            chk("stream_count", 32'(bus.Count), (BYP || i == 0) ? 32'd0 : 32'd1);
            if (BYP || i > 0) chk("stream_no_gap", 32'(bus.Out_Valid), 32'd1);
            tick();
        end
        drive_check(0, 0, 0, 1, 0);
        tick();
        drive_check(0, 0, 0, 0, 0);
        chk("stream_drained", 32'(bus.Count), 32'd0);
        tick();

        // Out_PC4 wraps modulo 2^32
        drive_check(1, 32'h0000000c, 32'hfffffffc, 0, 0);
        tick();
        drive_check(0, 0, 0, 1, 0);
        chk("pc4_wrap", bus.Out_PC4, 32'd0);
        tick();

`ifdef FETCH_QUEUE_BYPASS_EN
        // Zero-latency pass through an empty queue
        drive_check(1, 32'h24020005, RESET_PC, 1, 0);
        chk("byp_out_valid", 32'(bus.Out_Valid), 32'd1);
        chk("byp_out_pc",    bus.Out_PC, RESET_PC);
        tick();
        drive_check(0, 0, 0, 0, 0);
        chk("byp_count", 32'(bus.Count), 32'd0);
        tick();
`endif

        // Reset asserted with entries buffered: everything is lost
        drive_check(1, 32'h11111111, 32'h3100, 0, 0);
        tick();
        drive_check(1, 32'h22222222, 32'h3104, 0, 0);
        tick();
        Reset = 1'b0;
        #1;
        chk("midrst_count",     32'(bus.Count),     32'd0);
        chk("midrst_out_valid", 32'(bus.Out_Valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.In_Ready),  32'd0);
        sb.delete();
        live = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        drive_check(0, 0, 0, 0, 0);
        tick();
        drive_check(1, 32'h3c080001, RESET_PC, 0, 0);
        tick();
        drive_check(0, 0, 0, 1, 0);
        chk("midrst_new_head", bus.Out_PC, RESET_PC);
        tick();

        // Randomized traffic with occasional flushes
        rpc = RESET_PC;
        for (int i = 0; i < 300; i++) begin
            drive_check(1'($urandom_range(0, 1)), $urandom, rpc,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            rpc = rpc + 32'd4;
            tick();
        end
        drive_check(0, 0, 0, 0, 1);
        tick();
        drive_check(0, 0, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch unit and decode in the pipelined MIPS core. It accepts one fetched instruction word plus its address per cycle over a valid/ready handshake and buffers up to DEPTH entries. It presents the oldest entry to decode in program order. A flush input discards all buffered entries when a branch or jump redirects fetch.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- In_Valid  input  1  fetch presents a word this cycle.
- In_Ready  output  1  queue accepts the word this cycle.
- In_Instr  input  32  fetched instruction word.
- In_PC  input  32  address of In_Instr.
- Out_Valid  output  1  head entry is available to decode.
- Out_Ready  input  1  decode consumes the head this cycle.
- Out_Instr  output  32  head instruction; 32'h00000000 (nop) whenever Out_Valid=0.
- Out_PC  output  32  head address; 32'h00000000 whenever Out_Valid=0.
- Out_PC4  output  32  Out_PC + 4, modulo 2^32; 32'h00000000 whenever Out_Valid=0.
- Flush  input  1  discard all entries.
- Count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: In_Valid && In_Ready. Pop: Out_Valid && Out_Ready.
- Storage is a circular buffer with wr_ptr, rd_ptr and count.
- Pointer width is $clog2(DEPTH). Pointers wrap modulo DEPTH with no special case.
- In_Ready = (count != DEPTH) && !Flush. It does not depend on Out_Ready, so there is no ready pass-through when full.
- Out_Valid = (count != 0) && !Flush (see bypass under Configuration).
- Push only: the word is written at wr_ptr, wr_ptr increments, count increments.
- Pop only: rd_ptr increments, count decrements.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- Full (count=DEPTH): In_Ready=0, so a simultaneous pop does not enable a push. The push retries on the next cycle.
- Empty (count=0): Out_Valid=0 and the output data is zeroed.
- Flush has the highest priority. In the Flush cycle no push or pop occurs. At the next edge count=0, wr_ptr=0 and rd_ptr=0. Storage contents are don't-care.
- Reset (async, Reset=0): count and pointers go to 0 and storage is cleared to 0. Out_Valid=0, In_Ready=0 while Reset is asserted, and In_Ready=1 from the first edge after release.
- Reset asserted mid-transfer: all buffered entries are lost and no partial state survives.

## Timing
- Latency without bypass: a word pushed at edge N is visible with Out_Valid=1 after edge N.
- Sustained throughput is one word per cycle when Out_Ready is held at 1.
- All state updates happen on the rising edge of Clk, except reset, which is asynchronous.
- Outputs are combinational from state, plus Flush and (with bypass) In_* signals. There is no combinational path from Out_Ready to In_Ready.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined, and count=0 with no Flush:
  - Out_Valid = In_Valid, and Out_Instr/Out_PC/Out_PC4 are driven from In_*.
  - If Out_Ready=1, the word is consumed and not written; count stays 0.
  - If Out_Ready=0, the word is written normally.
  - Zero-cycle latency.
- FETCH_QUEUE_BYPASS_EN undefined: the empty queue always adds one cycle of latency, as described under Timing.

## Structure
- Shared package mips_pkg holds:
  - WORD_W = 32.
  - INSTR_NOP = 32'h00000000.
  - RESET_PC = 32'h00003000 (the fetch reset address; used by benches).
- Sub-module fq_storage: DEPTH x 64-bit register array holding {instr, pc}. It has write port (we, waddr, wdata), async read port (raddr, rdata), and async active-low clear.
- Pointer, count and handshake logic live in fetch_queue.

## Test plan
- Reset low, then release; In_Valid=0 -> Count=0, Out_Valid=0, Out_Instr=0; In_Ready=1 after the first edge.
- Push 0x34670404@0x3000, 0x24010001@0x3004 with Out_Ready=0 -> Count=2; Out_Instr=0x34670404, Out_PC=0x3000, Out_PC4=0x3004.
- Push DEPTH=4 words with Out_Ready=0 -> In_Ready=0 at Count=4. A 5th word held by fetch is accepted only on the cycle after the first pop.
- Continuous In_Valid=1 and Out_Ready=1 for 10 words starting at 0x3000 -> in-order output with no gaps; pointers wrap twice; Count stays at 1 (0 with bypass).
- Count=3 and Flush=1 with In_Valid=1 and Out_Ready=1 -> no transfer that cycle; Count=0 next cycle; the next pushed word at 0x3040 appears first.
- With FETCH_QUEUE_BYPASS_EN, empty queue, In_Valid=1 (0x3000), Out_Ready=1 -> Out_Valid=1 the same cycle, Out_PC=0x3000, Count stays 0.
